// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end for the divisible-by-5 detector.
// A word of up to WIDTH bits is accepted over a valid/ready handshake. It is then
// emitted one bit per cycle on out_bit/out_valid. The default order is MSB-first.
// out_start flags the first bit of a word and out_last flags the final bit.
//
// Optional feature macro: BIT_SERIALIZER_LSB_FIRST_EN. When it is defined, the
// word is emitted LSB-first.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous reset, active-high
//   in_valid  in_data/in_len valid
//   in_ready  word can be accepted this cycle
//   in_data   word; the used bits are in_data[len-1:0]
//   in_len    bits to emit; 0 or >WIDTH means WIDTH
//   out_ready downstream consumes out_bit this cycle
//   out_valid out_bit valid
//   out_bit   serial data bit
//   out_start first bit of a word
//   out_last  last bit of a word
//   busy      a word is loaded and not fully emitted
module bit_serializer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LEN_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [LEN_W-1:0] in_len,
   input  logic             out_ready,
   output logic             out_valid,
   output logic             out_bit,
   output logic             out_start,
   output logic             out_last,
   output logic             busy
);

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t           state, state_d;
   logic [WIDTH-1:0] sr, sr_d;
   logic [LEN_W-1:0] cnt, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;
   logic [LEN_W-1:0] eff_len;
   logic [WIDTH-1:0] load_word;
   logic             accept;
   logic             fire;

   // Clamp an illegal length (0 or >WIDTH) to the full width.
   always_comb begin
      eff_len = in_len;
      if (in_len == '0 || in_len > LEN_W'(WIDTH)) begin
         eff_len = LEN_W'(WIDTH);
      end
   end

`ifdef BIT_SERIALIZER_LSB_FIRST_EN
   // Right-aligned as given. Bits above len-1 never reach bit 0 before the count expires.
   assign load_word = in_data;
   assign out_bit   = sr[0];
`else
   // Left-align so that bit len-1 sits at the MSB. Unused upper bits shift out.
   assign load_word = in_data << (LEN_W'(WIDTH) - eff_len);
   assign out_bit   = sr[WIDTH-1];
`endif

   assign out_valid = (state == SHIFT);
   assign busy      = (state == SHIFT);
   assign out_start = (state == SHIFT) && (cnt == len_q);
   assign out_last  = (state == SHIFT) && (cnt == LEN_W'(1));
   assign in_ready  = (state == IDLE) || (out_last && out_ready);
   assign accept    = in_valid && in_ready;
   assign fire      = out_valid && out_ready;

   // State and datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         sr    <= '0;
         cnt   <= '0;
         len_q <= '0;
      end else begin
         state <= state_d;
         sr    <= sr_d;
         cnt   <= cnt_d;
         len_q <= len_d;
      end
   end

   // Next-state logic. A last-bit consume together with an accept reloads the
   // registers without a bubble.
   always_comb begin
      state_d = state;
      sr_d    = sr;
      cnt_d   = cnt;
      len_d   = len_q;
      unique case (state)
         IDLE: begin
            if (accept) begin
               state_d = SHIFT;
               sr_d    = load_word;
               cnt_d   = eff_len;
               len_d   = eff_len;
            end
         end
         SHIFT: begin
            if (fire) begin
               if (out_last) begin
                  if (accept) begin
                     sr_d  = load_word;
                     cnt_d = eff_len;
                     len_d = eff_len;
                  end else begin
                     state_d = IDLE;
                     cnt_d   = '0;
                  end
               end else begin
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
                  sr_d = sr >> 1;
`else
                  sr_d = sr << 1;
`endif
                  cnt_d = cnt - LEN_W'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer (WIDTH=8) with hand-computed expected values.
module tb_bit_serializer;

   localparam int unsigned WIDTH = 8;
   localparam int unsigned LEN_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic [LEN_W-1:0] in_len;
   logic             out_ready;
   logic             out_valid;
   logic             out_bit;
   logic             out_start;
   logic             out_last;
   logic             busy;

   int tests_run  = 0;
   int tests_fail = 0;

   bit_serializer #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_len    (in_len),
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_bit   (out_bit),
      .out_start (out_start),
      .out_last  (out_last),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one word, then collect its bits with out_ready held high.
   task automatic send(input logic [7:0] d, input logic [3:0] l,
                       output int n, output logic [31:0] bits,
                       output int last_idx, output int start_cnt);
      in_valid  = 1'b1;
      in_data   = d;
      in_len    = l;
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      n         = 0;
      bits      = '0;
      last_idx  = -1;
      start_cnt = 0;
      for (int c = 0; c < 40 && out_valid; c++) begin
         bits = {bits[30:0], out_bit};
         if (out_last) last_idx = n;
         if (out_start) start_cnt++;
         n++;
         step();
      end
      check("send_timeout", 32'(out_valid), 32'd0);
   endtask

   logic [5:0]  b2b_exp;
   logic [7:0]  stall_exp;
   logic [31:0] bits;
   logic [31:0] lsb_exp;
   int          n, last_idx, start_cnt, got_n, lasts;
   logic        prev_bit;

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_len    = '0;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_busy",      32'(busy),      32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_start",     32'(out_start), 32'd0);
      check("rst_last",      32'(out_last),  32'd0);
      check("rst_bit",       32'(out_bit),   32'd0);

      // Basic: 0x05 len 3 gives 1,0,1.
      in_valid = 1'b1; in_data = 8'h05; in_len = 4'd3;
      step();
      in_valid = 1'b0;
      check("basic_c1_valid", 32'(out_valid), 32'd1);
      check("basic_c1_bit",   32'(out_bit),   32'd1);
      check("basic_c1_start", 32'(out_start), 32'd1);
      check("basic_c1_last",  32'(out_last),  32'd0);
      check("basic_c1_rdy",   32'(in_ready),  32'd0);
      step();
      check("basic_c2_bit",   32'(out_bit),   32'd0);
      check("basic_c2_start", 32'(out_start), 32'd0);
      check("basic_c2_last",  32'(out_last),  32'd0);
      step();
      check("basic_c3_bit",   32'(out_bit),   32'd1);
      check("basic_c3_last",  32'(out_last),  32'd1);
      check("basic_c3_rdy",   32'(in_ready),  32'd1);
      step();
      check("basic_c4_valid", 32'(out_valid), 32'd0);
      check("basic_c4_rdy",   32'(in_ready),  32'd1);

      // Back-to-back: 0x0A len 4, then 0x03 len 2 with no gap.
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      b2b_exp = 6'b010111;
`else
      b2b_exp = 6'b101011;
`endif
      in_valid = 1'b1; in_data = 8'h0A; in_len = 4'd4;
      step();
      in_data = 8'h03; in_len = 4'd2;
      for (int i = 0; i < 6; i++) begin
         check($sformatf("b2b_valid%0d", i), 32'(out_valid), 32'd1);
         check($sformatf("b2b_bit%0d", i),   32'(out_bit),   32'(b2b_exp[5-i]));
         check($sformatf("b2b_start%0d", i), 32'(out_start), 32'(i == 0 || i == 4));
         check($sformatf("b2b_last%0d", i),  32'(out_last),  32'(i == 3 || i == 5));
         if (i < 4) check($sformatf("b2b_rdy%0d", i), 32'(in_ready), 32'(i == 3));
         if (i == 4) in_valid = 1'b0;
         step();
      end
      check("b2b_end_valid", 32'(out_valid), 32'd0);

      // Stall: 0xA5 len 8 with out_ready low in cycles 2..4.
      stall_exp = 8'hA5;
      in_valid = 1'b1; in_data = 8'hA5; in_len = 4'd8;
      step();
      in_valid = 1'b0;
      got_n = 0; lasts = 0; prev_bit = 1'b0;
      for (int c = 1; c < 20 && out_valid; c++) begin
         out_ready = !(c >= 2 && c <= 4);
         if (c >= 3 && c <= 5) begin
            check($sformatf("stall_hold_bit%0d", c), 32'(out_bit), 32'(prev_bit));
            check($sformatf("stall_hold_start%0d", c), 32'(out_start), 32'd0);
         end
         if (out_ready) begin
            check($sformatf("stall_bit%0d", got_n), 32'(out_bit), 32'(stall_exp[7-got_n]));
            if (out_last) lasts++;
            got_n++;
         end
         prev_bit = out_bit;
         step();
      end
      out_ready = 1'b1;
      check("stall_count", 32'(got_n), 32'd8);
      check("stall_lasts", 32'(lasts), 32'd1);
      check("stall_end_valid", 32'(out_valid), 32'd0);

      // Length clamp: len 0 and len 9 both mean 8.
      send(8'hFF, 4'd0, n, bits, last_idx, start_cnt);
      check("clamp0_n",     32'(n),        32'd8);
      check("clamp0_bits",  bits,          32'h0000_00FF);
      check("clamp0_last",  32'(last_idx), 32'd7);
      check("clamp0_start", 32'(start_cnt), 32'd1);
      send(8'hFF, 4'd9, n, bits, last_idx, start_cnt);
      check("clamp9_n",     32'(n),        32'd8);
      check("clamp9_bits",  bits,          32'h0000_00FF);
      check("clamp9_last",  32'(last_idx), 32'd7);

      // Upper bits beyond len are ignored: 0xF6 len 3 uses 3'b110.
      send(8'hF6, 4'd3, n, bits, last_idx, start_cnt);
`ifdef BIT_SERIALIZER_LSB_FIRST_EN
      lsb_exp = 32'b011;
`else
      lsb_exp = 32'b110;
`endif
      check("order_n",    32'(n),        32'd3);
      check("order_bits", bits,          lsb_exp);
      check("order_last", 32'(last_idx), 32'd2);

      // Reset mid-word: 0xF0 len 8, reset after bit 3.
      in_valid = 1'b1; in_data = 8'hF0; in_len = 4'd8;
      step();
      in_valid = 1'b0;
      step();
      step();
      check("mid_bit3", 32'(out_bit), 32'd1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("mid_valid", 32'(out_valid), 32'd0);
      check("mid_busy",  32'(busy),      32'd0);
      check("mid_rdy",   32'(in_ready),  32'd1);
      check("mid_last",  32'(out_last),  32'd0);
      in_valid = 1'b1; in_data = 8'h01; in_len = 4'd1;
      step();
      in_valid = 1'b0;
      check("len1_valid", 32'(out_valid), 32'd1);
      check("len1_bit",   32'(out_bit),   32'd1);
      check("len1_start", 32'(out_start), 32'd1);
      check("len1_last",  32'(out_last),  32'd1);
      check("len1_rdy",   32'(in_ready),  32'd1);
      step();
      check("len1_end_valid", 32'(out_valid), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
      $finish;
   end

endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial front end for the divisible-by-5 detector.
- Accepts a word of up to WIDTH bits over a valid/ready handshake and emits it one bit per cycle, MSB-first, on out_bit/out_valid.
- out_bit drives the detector's in_bit. out_start marks the first bit of each word so downstream can restart its remainder per word. out_last marks the final bit of each word.

Parameters:
- WIDTH, 8, maximum word length in bits; legal range 1..32.
- LEN_W, $clog2(WIDTH+1), width of in_len.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data/in_len are valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  word; the used bits are in_data[len-1:0].
- in_len  input  LEN_W  number of bits to emit; 0 or >WIDTH is treated as WIDTH.
- out_ready  input  1  downstream consumes out_bit this cycle; tie high for the detector.
- out_valid  output  1  out_bit is valid.
- out_bit  output  1  serial data bit.
- out_start  output  1  qualifies out_valid: first bit of a word.
- out_last  output  1  qualifies out_valid: last bit of a word.
- busy  output  1  a word is loaded and not yet fully emitted.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0 except in_ready, which is 1 in the first cycle after reset deasserts.
- FSM states:
  - IDLE: in_ready=1, out_valid=0.
  - SHIFT: out_valid=1.
- Accept: a word is accepted when in_valid && in_ready at a clock edge. The edge after acceptance enters SHIFT with:
  - shift register = in_data left-aligned so bit len-1 sits at the MSB;
  - bit counter = effective length.
  - Latency is 1 cycle: the first bit is on out_bit in the cycle after the accept edge.
- SHIFT:
  - out_bit = current MSB of the shift register.
  - On out_valid && out_ready: shift left by 1 and decrement the counter.
  - out_start=1 only while the counter equals the loaded length.
  - out_last=1 when the counter is 1.
- Stall: when out_ready=0, out_bit, out_start, out_last and the counter hold exactly.
- Completion: the last bit is consumed when out_last && out_ready.
  - If in_ready && in_valid in that same cycle, load the new word and stay in SHIFT. This gives a zero-bubble back-to-back stream.
  - Otherwise return to IDLE.
- in_ready = IDLE || (out_last && out_ready). It is combinational from out_ready but registered from the FSM state.
- Length 1: out_start and out_last are both 1 on the single bit.
- Length handling: in_len==0 or in_len>WIDTH is clamped to WIDTH. Bits of in_data above len-1 are ignored.
- Reset mid-word: the current word is dropped with no partial out_last. out_valid is 0 in the first cycle after reset deasserts.
- busy=1 in SHIFT.
- A word is never accepted while a non-last bit is pending.

Optional Feature:
- Macro: BIT_SERIALIZER_LSB_FIRST_EN.
- Defined: bits are emitted LSB-first. in_data[0] goes first, the register shifts right, and the word is right-aligned with no realignment. out_start, out_last, stall and handshake timing are unchanged.
- Undefined (default): MSB-first exactly as specified above.

Test Plan:
- Basic word, out_ready=1: in_data=8'h05, in_len=3 accepted at cycle 0 -> cycles 1..3 give out_bit=1,0,1; out_start at cycle 1, out_last at cycle 3; cycle 4 out_valid=0, in_ready=1. A detector fed this stream flags divisible at cycle 4.
- Back-to-back: 8'h0A len 4, then 8'h03 len 2 held valid -> bits 1,0,1,0,1,1 on 6 consecutive cycles with no gap; in_ready=1 only in the last-bit cycle of the first word; out_start at bits 1 and 5.
- Stall: 8'hA5 len 8 with out_ready=0 in cycles 2-4 -> out_bit and the counter frozen during the stall; the full sequence 1,0,1,0,0,1,0,1 is still emitted; out_last exactly once.
- Length clamp: in_len=0 and in_len=9 with WIDTH=8 and in_data=8'hFF -> 8 ones each; out_last on the 8th bit.
- Reset mid-word: rst asserted after bit 3 of 8'hF0 len 8 -> cycle after rst deasserts: out_valid=0, busy=0, in_ready=1; the next word 8'h01 len 1 emits a single bit 1 with out_start=out_last=1.
- With BIT_SERIALIZER_LSB_FIRST_EN: 8'h06 len 3 -> 0,1,1.
